// File: rtl/pet_pkg.sv
// Shared types for the pet stats engine: life-cycle states and the command byte map.
// Command bytes select which stat a care action lowers; 'r' revives a dead pet.
package pet_pkg;

    typedef enum logic [1:0] {
        PET_ALIVE = 2'd0,
        PET_SICK  = 2'd1,
        PET_DEAD  = 2'd2
    } pet_state_t;

    localparam logic [7:0] CMD_STAT0  = 8'h65;  // 'e'
    localparam logic [7:0] CMD_STAT1  = 8'h73;  // 's'
    localparam logic [7:0] CMD_STAT2  = 8'h68;  // 'h'
    localparam logic [7:0] CMD_STAT3  = 8'h77;  // 'w'
    localparam logic [7:0] CMD_STAT4  = 8'h7A;  // 'z'
    localparam logic [7:0] CMD_STAT5  = 8'h70;  // 'p'
    localparam logic [7:0] CMD_STAT6  = 8'h66;  // 'f'
    localparam logic [7:0] CMD_STAT7  = 8'h67;  // 'g'
    localparam logic [7:0] CMD_REVIVE = 8'h72;  // 'r'

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } cmd_map_t;

    function automatic cmd_map_t cmd_to_stat(input logic [7:0] b);
        cmd_map_t m;
        m.valid = 1'b1;
        m.idx   = 3'd0;
        case (b)
            CMD_STAT0: m.idx = 3'd0;
            CMD_STAT1: m.idx = 3'd1;
            CMD_STAT2: m.idx = 3'd2;
            CMD_STAT3: m.idx = 3'd3;
            CMD_STAT4: m.idx = 3'd4;
            CMD_STAT5: m.idx = 3'd5;
            CMD_STAT6: m.idx = 3'd6;
            CMD_STAT7: m.idx = 3'd7;
            default:   m.valid = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pet_tick_gen.sv
// Aging tick generator: tick is high during the last cycle of every TICK_CYCLES period,
// and second flips on that edge to drive the renderer's animation phase.
module pet_tick_gen #(
    parameter int TICK_CYCLES = 27000000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick,
    output logic second
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count  <= '0;
            second <= 1'b0;
        end else if (tick) begin
            count  <= '0;
            second <= ~second;
        end else begin
            count  <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pet_stats_engine.sv
// Pet stats engine: NUM_STATS saturating stats aged by tick/random and lowered by UART commands,
// with an ALIVE/SICK/DEAD life cycle. Optional command lockout: PET_STATS_CMD_COOLDOWN_EN.
//   state     | meaning
//   PET_ALIVE | healthy, no stat at MAX
//   PET_SICK  | some stat at MAX; sick_cnt counts consecutive sick ticks
//   PET_DEAD  | stats frozen, only revive accepted
module pet_stats_engine
    import pet_pkg::*;
#(
    parameter int NUM_STATS      = 6,
    parameter int STAT_W         = 4,
    parameter int TICK_CYCLES    = 27000000,
    parameter int SICK_LIMIT     = 10,
    parameter int COOLDOWN_TICKS = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [7:0]                  cmd_data,
    input  logic                        cmd_valid,
    input  logic [7:0]                  random,
    output logic                        second,
    output logic [NUM_STATS*STAT_W-1:0] stats,
    output logic [NUM_STATS-1:0]        critical,
    output logic [1:0]                  pet_state,
    output logic                        cmd_ack
);

    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic                        tick;
    pet_state_t                  state_q;
    logic [7:0]                  sick_cnt;
    logic [NUM_STATS*STAT_W-1:0] stats_d;
    logic [NUM_STATS-1:0]        crit_d;
    cmd_map_t                    cmd_map;
    logic                        cool_block;
    logic                        stat_cmd;
    logic                        revive;
    logic                        age;

    pet_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .second  (second)
    );

    assign cmd_map  = cmd_to_stat(cmd_data);
    assign revive   = cmd_valid && (cmd_data == CMD_REVIVE) && (state_q == PET_DEAD);
    assign stat_cmd = cmd_valid && cmd_map.valid && ({1'b0, cmd_map.idx} < 4'(NUM_STATS))
                      && (state_q != PET_DEAD) && !cool_block;
    assign age      = tick && (state_q != PET_DEAD) && ({1'b0, random[2:0]} < 4'(NUM_STATS));

    // Aging and a command on the same stat cancel, so MAX and 0 stay put in that case.
    for (genvar i = 0; i < NUM_STATS; i++) begin : g_stat
        logic              inc;
        logic              dec;
        logic [STAT_W-1:0] cur;
        assign cur = stats[i*STAT_W +: STAT_W];
        assign inc = age && (random[2:0] == 3'(i));
        assign dec = stat_cmd && (cmd_map.idx == 3'(i));
        assign stats_d[i*STAT_W +: STAT_W] =
            revive                                ? '0 :
            (inc && !dec && (cur != STAT_MAX))    ? cur + 1'b1 :
            (dec && !inc && (cur != '0))          ? cur - 1'b1 : cur;
        assign crit_d[i]   = (stats_d[i*STAT_W +: STAT_W] == STAT_MAX);
        assign critical[i] = (cur == STAT_MAX);
    end

`ifdef PET_STATS_CMD_COOLDOWN_EN
    logic [7:0] cool_cnt;
    logic       unused_bits;
    assign cool_block  = (cool_cnt != 8'd0);
    assign unused_bits = ^random[7:3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cool_cnt <= 8'd0;
        end else if (revive) begin
            cool_cnt <= 8'd0;
        end else if (stat_cmd) begin
            cool_cnt <= 8'(COOLDOWN_TICKS);
        end else if (tick && cool_block) begin
            cool_cnt <= cool_cnt - 8'd1;
        end
    end
`else
    logic unused_bits;
    assign cool_block  = 1'b0;
    assign unused_bits = ^{random[7:3], 32'(COOLDOWN_TICKS)};
`endif

    assign pet_state = state_q;

    // Life cycle is judged on the stats as they will be after this cycle's update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stats    <= '0;
            state_q  <= PET_ALIVE;
            sick_cnt <= 8'd0;
            cmd_ack  <= 1'b0;
        end else begin
            stats   <= stats_d;
            cmd_ack <= stat_cmd || revive;
            if (revive) begin
                state_q  <= PET_ALIVE;
                sick_cnt <= 8'd0;
            end else if (tick) begin
                case (state_q)
                    PET_ALIVE: begin
                        if (|crit_d) begin
                            state_q  <= PET_SICK;
                            sick_cnt <= 8'd1;
                        end
                    end
                    PET_SICK: begin
                        if (!(|crit_d)) begin
                            state_q  <= PET_ALIVE;
                            sick_cnt <= 8'd0;
                        end else begin
                            sick_cnt <= sick_cnt + 8'd1;
                            if ((sick_cnt + 8'd1) >= 8'(SICK_LIMIT)) begin
                                state_q <= PET_DEAD;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/pet_stats_engine.md
Name: pet_stats_engine

Overview:
Parametrised successor of the single-pet stats block: holds NUM_STATS saturating counters of STAT_W bits, ages them on a programmable tick using an external random byte, and lowers them on one-shot command bytes from the UART receiver. Adds a pet life-cycle FSM (ALIVE/SICK/DEAD) and a per-stat critical mask. Sits between the UART RX / LFSR and the sprite/animation renderer.

Parameters:
NUM_STATS, 6, number of stat counters (1..8)
STAT_W, 4, width of each stat; MAX = 2**STAT_W-1
TICK_CYCLES, 27000000, clk cycles per aging tick
SICK_LIMIT, 10, consecutive SICK ticks before DEAD (1..255)
COOLDOWN_TICKS, 2, ticks of command lockout (optional feature only)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_data  in  8  ASCII command byte
cmd_valid  in  1  one-cycle strobe, cmd_data valid
random  in  8  LFSR value, sampled on tick cycle
second  out  1  toggles every tick (animation phase)
stats  out  NUM_STATS*STAT_W  stat i at [i*STAT_W +: STAT_W]
critical  out  NUM_STATS  bit i = stat i == MAX
pet_state  out  2  0 ALIVE, 1 SICK, 2 DEAD
cmd_ack  out  1  one-cycle pulse, command accepted

Behaviour:
- Reset (async, reset_n low): all stats 0, second 0, pet_state ALIVE, cmd_ack 0, tick counter 0, sick counter 0, cooldown 0. All outputs registered; critical derived from registered stats.
- Tick: counter 0..TICK_CYCLES-1; tick asserted internally on cycle counter==TICK_CYCLES-1, counter wraps to 0. second toggles on tick in every state.
- Aging (tick, state != DEAD): idx = random[2:0]; if idx < NUM_STATS, stat[idx] += 1 saturating at MAX; else no change.
- Command map: 'e'(0x65)->stat0, 's'(0x73)->stat1, 'h'(0x68)->stat2, 'w'(0x77)->stat3, 'z'(0x7A)->stat4, 'p'(0x70)->stat5, 'f'(0x66)->stat6, 'g'(0x67)->stat7; 'r'(0x72) = revive. Mapped index >= NUM_STATS or unknown byte: ignored, no ack.
- Accepted command (ALIVE or SICK): stat -= 1 saturating at 0 (ack even if already 0). Update and cmd_ack visible one cycle after the cmd_valid cycle. Each cmd_valid pulse applied exactly once; held cmd_valid counts as one pulse per cycle high (UART delivers single-cycle strobes).
- Same cycle aging and command on same stat: net unchanged (including at 0 and MAX). Different stats: both applied.
- FSM evaluated on tick using post-update stats:
  ALIVE -> SICK when any critical bit set; sick counter = 1.
  SICK -> ALIVE when no critical bit; sick counter = 0.
  SICK, still critical: sick counter += 1; reaching SICK_LIMIT -> DEAD.
  DEAD: stats frozen, no aging; only 'r' accepted: stats 0, sick counter 0, pet_state ALIVE, cmd_ack pulse. 'r' in ALIVE/SICK ignored, no ack.
- Revive and tick in same cycle: revive wins; no aging that cycle.

Optional Feature:
Macro PET_STATS_CMD_COOLDOWN_EN. Defined: after any accepted stat command, further stat commands ignored (no ack) until COOLDOWN_TICKS ticks have elapsed; cooldown counter cleared by reset and revive; 'r' never blocked. Undefined: no cooldown, COOLDOWN_TICKS unused, every valid command accepted.

Decomposition:
Shared package pet_pkg: pet_state enum (ALIVE/SICK/DEAD, 2 bits), command ASCII constants, CMD_REVIVE, function mapping byte->stat index with valid flag. One natural sub-module: pet_tick_gen (counter, tick pulse, second toggle), parametrised by TICK_CYCLES. Saturating counters stay inline as a generate loop.

Test Plan:
- Reset/tick: TICK_CYCLES=10, release reset_n -> all stats 0, second toggles on cycles 10, 20, 30; random=3'b111 every tick -> stats unchanged.
- Aging/saturation: STAT_W=4, random[2:0]=0 for 17 ticks -> stat0 = 15 after 15th tick, stays 15, critical[0]=1.
- Command: stat1=3, pulse 's' -> next cycle stat1=2, cmd_ack=1 one cycle; 's' at stat1=0 -> stays 0, ack=1; byte 'q' -> no ack; 'f' with NUM_STATS=6 -> no ack.
- Collision: stat0=5, tick with random=0 and 'e' same cycle -> stat0 stays 5; stat0=15 same collision -> stays 15.
- Life-cycle: SICK_LIMIT=3, stat0 held 15 -> SICK on first tick, DEAD on third; 'e' in DEAD -> no ack; 'r' -> stats 0, ALIVE, ack; feed 'e' in SICK bringing stat0 to 14 -> ALIVE next tick.
- Cooldown (macro defined, COOLDOWN_TICKS=2): 'e' acked, 'e' before 2 ticks -> no ack, after 2 ticks -> acked; async reset_n low mid-cooldown -> all cleared immediately.
